// File: rtl/dac_rst_sequencer.sv
// Avalon-MM master that pulses the DAC reset PIO low for HOLD_CYCLES, releases it, then waits RECOVER_CYCLES.
// Define DAC_RST_READBACK_EN to read back the PIO after each write and flag mismatches on error.
module dac_rst_sequencer #(
  parameter int unsigned PIO_ADDR       = 0,
  parameter int unsigned HOLD_CYCLES    = 1000,
  parameter int unsigned RECOVER_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic        avm_read_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE, WR_LOW, RD_LOW, HOLD, WR_HIGH, RD_HIGH, RECOVER, FINISH
  } state_t;

  localparam logic [23:0] HOLD_LOAD    = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] RECOVER_LOAD = (RECOVER_CYCLES == 0) ? 24'd0 : 24'(RECOVER_CYCLES - 1);

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  // req_q marks the request phase of a read; once accepted we wait for readdatavalid
  logic        req_q, req_d;
  logic        err_q, err_d;
  logic        busy_q, done_q, cs_q, wn_q, rn_q, wd_q;
  logic        wr_next, rd_next;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = WR_LOW;
        err_d   = 1'b0;
      end
      WR_LOW: if (!avm_waitrequest) begin
`ifdef DAC_RST_READBACK_EN
        state_d = RD_LOW;
        req_d   = 1'b1;
`else
        state_d = HOLD;
        cnt_d   = HOLD_LOAD;
`endif
      end
`ifdef DAC_RST_READBACK_EN
      RD_LOW: begin
        if (req_q) begin
          if (!avm_waitrequest) req_d = 1'b0;
        end else if (avm_readdatavalid) begin
          if (avm_readdata[0]) begin
            err_d   = 1'b1;
            state_d = WR_HIGH;
          end else begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      RD_HIGH: begin
        if (req_q) begin
          if (!avm_waitrequest) req_d = 1'b0;
        end else if (avm_readdatavalid) begin
          if (!avm_readdata[0]) err_d = 1'b1;
          state_d = RECOVER;
          cnt_d   = RECOVER_LOAD;
        end
      end
`endif
      HOLD: begin
        if (abort || cnt_q == 24'd0) state_d = WR_HIGH;
        else                         cnt_d   = cnt_q - 24'd1;
      end
      WR_HIGH: if (!avm_waitrequest) begin
`ifdef DAC_RST_READBACK_EN
        state_d = RD_HIGH;
        req_d   = 1'b1;
`else
        state_d = RECOVER;
        cnt_d   = RECOVER_LOAD;
`endif
      end
      RECOVER: begin
        if (cnt_q == 24'd0) state_d = FINISH;
        else                cnt_d   = cnt_q - 24'd1;
      end
      FINISH: begin
        state_d = IDLE;
        cnt_d   = 24'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state
  assign wr_next = (state_d == WR_LOW) || (state_d == WR_HIGH);
  assign rd_next = ((state_d == RD_LOW) || (state_d == RD_HIGH)) && req_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 24'd0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      rn_q    <= 1'b1;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FINISH);
      cs_q    <= wr_next || rd_next;
      wn_q    <= !wr_next;
      rn_q    <= !rd_next;
      wd_q    <= (state_d == WR_HIGH);
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_address    = 2'(PIO_ADDR);
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = {31'd0, wd_q};
  assign state_dbg      = state_q;

`ifdef DAC_RST_READBACK_EN
  assign error      = err_q;
  assign avm_read_n = rn_q;
  logic unused_ok;
  assign unused_ok  = ^avm_readdata[31:1];
`else
  assign error      = 1'b0;
  assign avm_read_n = 1'b1;
  logic unused_ok;
  assign unused_ok  = ^{avm_readdata, avm_readdatavalid, err_q, rn_q};
`endif

endmodule

// File: tb/tb_dac_rst_sequencer.sv
// Directed bench for dac_rst_sequencer: exact cycle timing, stalls, abort, start-while-busy, reset and readback.
module tb_dac_rst_sequencer;

  logic        clk, reset;
  logic        start_s, start_l, abort;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;

  logic        busy_s, done_s, error_s, cs_s, wn_s, rn_s;
  logic [1:0]  addr_s;
  logic [31:0] wd_s;
  logic [2:0]  st_s;
  logic        busy_l, done_l, error_l, cs_l, wn_l, rn_l;
  logic [1:0]  addr_l;
  logic [31:0] wd_l;
  logic [2:0]  st_l;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model state
  logic pio_bit   = 1'b1;
  logic rd_pend   = 1'b0;
  logic corrupt   = 1'b0;
  int   n_high_wr = 0;

  dac_rst_sequencer #(.PIO_ADDR(0), .HOLD_CYCLES(4), .RECOVER_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort),
    .busy(busy_s), .done(done_s), .error(error_s),
    .avm_address(addr_s), .avm_chipselect(cs_s), .avm_write_n(wn_s),
    .avm_read_n(rn_s), .avm_writedata(wd_s), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .state_dbg(st_s)
  );

  dac_rst_sequencer #(.PIO_ADDR(0), .HOLD_CYCLES(1000), .RECOVER_CYCLES(2)) u_long (
    .clk(clk), .reset(reset), .start(start_l), .abort(abort),
    .busy(busy_l), .done(done_l), .error(error_l),
    .avm_address(addr_l), .avm_chipselect(cs_l), .avm_write_n(wn_l),
    .avm_read_n(rn_l), .avm_writedata(wd_l), .avm_readdata(32'd0),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(1'b0),
    .state_dbg(st_l)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PIO slave on u_dut: reads return data the cycle after acceptance
  always @(negedge clk) begin
    avm_readdatavalid = rd_pend;
    avm_readdata      = {31'd0, corrupt ? 1'b1 : pio_bit};
    rd_pend           = cs_s && !rn_s && !avm_waitrequest;
    if (cs_s && !wn_s && !avm_waitrequest) begin
      pio_bit = wd_s[0];
      if (wd_s[0]) n_high_wr++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " busy"},  busy_s, 0);
    check_eq({tag, " done"},  done_s, 0);
    check_eq({tag, " error"}, error_s, 0);
    check_eq({tag, " cs"},    cs_s, 0);
    check_eq({tag, " wn"},    wn_s, 1);
    check_eq({tag, " rn"},    rn_s, 1);
    check_eq({tag, " addr"},  addr_s, 0);
    check_eq({tag, " wd"},    wd_s, 0);
    check_eq({tag, " state"}, st_s, 0);
  endtask

  task automatic pulse_start_s();
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
  endtask

  // Waits for done with a cycle budget; cycles counted from the accepted start edge
  task automatic wait_done(input int budget, output int cycles, output bit seen);
    seen = 1'b0; cycles = 0;
    for (int i = 1; i <= budget && !seen; i++) begin
      if (done_s) begin seen = 1'b1; cycles = i; end
      else @(negedge clk);
    end
  endtask

`ifndef DAC_RST_READBACK_EN
  // start at edge S; position c is the value sampled at edge S+c
  task automatic run_basic(input string tag);
    pulse_start_s();
    for (int c = 1; c <= 11; c++) begin
      start_s = (c == 3 || c == 7 || c == 9);
      check_eq($sformatf("%s busy c%0d", tag, c), busy_s, (c <= 9) ? 1 : 0);
      check_eq($sformatf("%s done c%0d", tag, c), done_s, (c == 9) ? 1 : 0);
      check_eq($sformatf("%s cs c%0d", tag, c),   cs_s, (c == 1 || c == 6) ? 1 : 0);
      check_eq($sformatf("%s wn c%0d", tag, c),   wn_s, (c == 1 || c == 6) ? 0 : 1);
      check_eq($sformatf("%s wd c%0d", tag, c),   wd_s, (c == 6) ? 1 : 0);
      check_eq($sformatf("%s err c%0d", tag, c),  error_s, 0);
      check_eq($sformatf("%s rn c%0d", tag, c),   rn_s, 1);
      @(negedge clk);
    end
    start_s = 1'b0;
  endtask
`endif

  int  cyc;
  bit  seen;

  initial begin
    reset = 1'b1; start_s = 1'b0; start_l = 1'b0; abort = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    check_eq("por long busy", busy_l, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

`ifndef DAC_RST_READBACK_EN
    run_basic("basic");

    // low write stalled 3 cycles
    pulse_start_s();
    for (int c = 1; c <= 13; c++) begin
      avm_waitrequest = (c <= 3);
      check_eq($sformatf("stall cs c%0d", c),   cs_s, (c <= 4 || c == 9) ? 1 : 0);
      check_eq($sformatf("stall wn c%0d", c),   wn_s, (c <= 4 || c == 9) ? 0 : 1);
      check_eq($sformatf("stall wd c%0d", c),   wd_s, (c == 9) ? 1 : 0);
      check_eq($sformatf("stall done c%0d", c), done_s, (c == 12) ? 1 : 0);
      check_eq($sformatf("stall busy c%0d", c), busy_s, (c <= 12) ? 1 : 0);
      @(negedge clk);
    end
    avm_waitrequest = 1'b0;

    // abort in 2nd HOLD cycle on the HOLD_CYCLES=1000 instance
    @(negedge clk); start_l = 1'b1;
    @(negedge clk); start_l = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      abort = (c == 3);
      check_eq($sformatf("abort cs c%0d", c),   cs_l, (c == 1 || c == 4) ? 1 : 0);
      check_eq($sformatf("abort wd c%0d", c),   wd_l, (c == 4) ? 1 : 0);
      check_eq($sformatf("abort done c%0d", c), done_l, (c == 7) ? 1 : 0);
      check_eq($sformatf("abort busy c%0d", c), busy_l, (c <= 7) ? 1 : 0);
      @(negedge clk);
    end
    abort = 1'b0;
`else
    // slave returns 1 on every read: low readback mismatches
    corrupt = 1'b1; n_high_wr = 0;
    pulse_start_s();
    wait_done(100, cyc, seen);
    check_eq("rb1 done seen", seen, 1);
    check_eq("rb1 error", error_s, 1);
    check_eq("rb1 high write", n_high_wr, 1);
    @(negedge clk);
    check_eq("rb1 error sticky", error_s, 1);
    corrupt = 1'b0;
    pulse_start_s();
    check_eq("rb2 error cleared", error_s, 0);
    wait_done(100, cyc, seen);
    check_eq("rb2 done seen", seen, 1);
    check_eq("rb2 error", error_s, 0);
    @(negedge clk);
`endif

    // asynchronous reset during HOLD
    pulse_start_s();
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

`ifndef DAC_RST_READBACK_EN
    run_basic("after_reset");
`endif
    pulse_start_s();
    wait_done(200, cyc, seen);
    check_eq("final done seen", seen, 1);
`ifndef DAC_RST_READBACK_EN
    check_eq("final latency", cyc, 9);
`endif
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
